// File: rtl/mdu_if.sv
// Request/response bundle between the EXE stage and the iterative multiply/divide unit.
interface mdu_if #(
  parameter int WIDTH = 32
);
  logic                 start;
  logic [2:0]           op;
  logic [WIDTH-1:0]     src0;
  logic [WIDTH-1:0]     src1;
  logic [2*WIDTH-1:0]   hilo_i;
  logic                 flush;
  logic                 busy;
  logic                 done;
  logic [2*WIDTH-1:0]   result;
  logic                 div_zero;

  modport master (
    output start, op, src0, src1, hilo_i, flush,
    input  busy, done, result, div_zero
  );

  modport slave (
    input  start, op, src0, src1, hilo_i, flush,
    output busy, done, result, div_zero
  );
endinterface

// File: rtl/mdu_iter.sv
// Iterative radix-2 multiply/divide unit: MULT/MULTU/MADD/MADDU/MSUB/MSUBU/DIV/DIVU.
// Works on operand magnitudes for WIDTH cycles, then applies sign/accumulate fixups in one cycle.
module mdu_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input logic clk,
  input logic rst,
  mdu_if.slave bus
);
  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  logic [1:0]           state_reg, state_next;
  logic [CNT_W-1:0]     cnt_reg;
  logic [2:0]           op_reg;
  logic [WIDTH-1:0]     mag0_reg, mag1_reg;
  logic                 sign0_reg, sign1_reg;
  logic [2*WIDTH-1:0]   hilo_reg, work_reg, result_reg;
  logic                 div_zero_reg;

  // Operand capture: magnitudes only for signed ops (even op codes).
  logic                 in_signed, in_neg0, in_neg1, in_div;
  logic [WIDTH-1:0]     in_mag0, in_mag1;

  always_comb begin
    in_signed = ~bus.op[0];
    in_div    = bus.op[2] & bus.op[1];
    in_neg0   = in_signed & bus.src0[WIDTH-1];
    in_neg1   = in_signed & bus.src1[WIDTH-1];
    in_mag0   = in_neg0 ? (~bus.src0 + 1'b1) : bus.src0;
    in_mag1   = in_neg1 ? (~bus.src1 + 1'b1) : bus.src1;
  end

  logic is_div, is_madd, is_msub, signs_differ;
  assign is_div       = op_reg[2] & op_reg[1];
  assign is_madd      = (op_reg[2:1] == 2'b01);
  assign is_msub      = (op_reg[2:1] == 2'b10);
  assign signs_differ = sign0_reg ^ sign1_reg;

  // Multiply step: hi += multiplicand when multiplier LSB set, then shift the pair right.
  logic [WIDTH:0]       mul_sum;
  logic [2*WIDTH-1:0]   mul_next;
  // Divide step: shift {rem,quot} left, subtract divisor if it fits.
  logic [WIDTH:0]       rem_sh, rem_diff;
  logic                 div_ge;
  logic [2*WIDTH-1:0]   div_next;

  always_comb begin
    mul_sum  = {1'b0, work_reg[2*WIDTH-1:WIDTH]} + (work_reg[0] ? {1'b0, mag0_reg} : '0);
    mul_next = {mul_sum, work_reg[WIDTH-1:1]};
    rem_sh   = {work_reg[2*WIDTH-1:WIDTH], work_reg[WIDTH-1]};
    div_ge   = (rem_sh >= {1'b0, mag1_reg});
    rem_diff = rem_sh - {1'b0, mag1_reg};
    div_next = {(div_ge ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0]), work_reg[WIDTH-2:0], div_ge};
  end

  // Final sign correction, accumulate, and divide-by-zero override.
  logic [2*WIDTH-1:0]   prod_s, mul_result, div_result, fix_result;
  logic [WIDTH-1:0]     quot_fix, rem_fix, src0_raw;
  logic                 div_by_zero;

  always_comb begin
    prod_s      = signs_differ ? (~work_reg + 1'b1) : work_reg;
    mul_result  = prod_s;
    if (is_madd) mul_result = hilo_reg + prod_s;
    if (is_msub) mul_result = hilo_reg - prod_s;
    quot_fix    = signs_differ ? (~work_reg[WIDTH-1:0] + 1'b1) : work_reg[WIDTH-1:0];
    rem_fix     = sign0_reg ? (~work_reg[2*WIDTH-1:WIDTH] + 1'b1) : work_reg[2*WIDTH-1:WIDTH];
    src0_raw    = sign0_reg ? (~mag0_reg + 1'b1) : mag0_reg;
    div_by_zero = (mag1_reg == '0);
    div_result  = div_by_zero ? {src0_raw, {WIDTH{1'b1}}} : {rem_fix, quot_fix};
    fix_result  = is_div ? div_result : mul_result;
  end

  always_comb begin
    state_next = state_reg;
    if (bus.flush) begin
      state_next = ST_IDLE;
    end else begin
      case (state_reg)
        ST_IDLE: if (bus.start) state_next = ST_CALC;
        ST_CALC: if (cnt_reg == CNT_W'(WIDTH-1)) state_next = ST_FIX;
        ST_FIX:  state_next = ST_DONE;
        default: state_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_IDLE;
      cnt_reg      <= '0;
      op_reg       <= '0;
      mag0_reg     <= '0;
      mag1_reg     <= '0;
      sign0_reg    <= 1'b0;
      sign1_reg    <= 1'b0;
      hilo_reg     <= '0;
      work_reg     <= '0;
      result_reg   <= '0;
      div_zero_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      case (state_reg)
        ST_IDLE: begin
          if (bus.start && !bus.flush) begin
            op_reg    <= bus.op;
            mag0_reg  <= in_mag0;
            mag1_reg  <= in_mag1;
            sign0_reg <= in_neg0;
            sign1_reg <= in_neg1;
            hilo_reg  <= bus.hilo_i;
            cnt_reg   <= '0;
            work_reg  <= in_div ? {{WIDTH{1'b0}}, in_mag0} : {{WIDTH{1'b0}}, in_mag1};
          end
        end
        ST_CALC: begin
          cnt_reg  <= cnt_reg + CNT_W'(1);
          work_reg <= is_div ? div_next : mul_next;
        end
        ST_FIX: begin
          // A flushed op must leave the previous result visible.
          if (!bus.flush) begin
            result_reg   <= fix_result;
            div_zero_reg <= is_div & div_by_zero;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.busy     = (state_reg != ST_IDLE);
  assign bus.done     = (state_reg == ST_DONE);
  assign bus.result   = result_reg;
  assign bus.div_zero = div_zero_reg;
endmodule

// File: doc/mdu_iter.md
Name: mdu_iter

Overview:
- Parametrised multi-cycle multiply/divide unit in EXE, alongside the single-cycle ALU.
- Replaces the combinational 32x32 multiply, covering MULT/MULTU/MADD/MADDU/MSUB/MSUBU.
- Adds DIV/DIVU, which the ALU does not support.
- Iterative radix-2 datapath. The pipeline stalls on `busy`, takes `{hi,lo}` on `done`, and aborts via `flush` on exception or branch cancel.

Parameters:
- WIDTH, 32: operand width in bits. `result` is 2*WIDTH bits. Must be even and ≥ 4.
- CNT_W, 6: iteration counter width. Must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request to begin an op. Sampled only in IDLE.
- op  in  3  0 MULT, 1 MULTU, 2 MADD, 3 MADDU, 4 MSUB, 5 MSUBU, 6 DIV, 7 DIVU.
- src0  in  WIDTH  multiplicand or dividend (rs).
- src1  in  WIDTH  multiplier or divisor (rt).
- hilo_i  in  2*WIDTH  current `{hi,lo}` accumulator for MADD/MSUB. Sampled with `start`.
- flush  in  1  abort the in-flight op.
- busy  out  1  high from the cycle after accepted `start` until the cycle `done` is asserted (inclusive).
- done  out  1  one-cycle pulse: `result` valid.
- result  out  2*WIDTH  `{hi,lo}`.
  - Multiply: full product or accumulated value.
  - Divide: `{remainder, quotient}`.
- div_zero  out  1  valid with `done`: divide op had src1 == 0.

Behaviour:
- Reset values: `busy`=0, `done`=0, `result`=0, `div_zero`=0, FSM=IDLE, counter=0.
- States and transitions:
  - IDLE → CALC on `start` && !`flush`.
  - CALC → FIX when counter == WIDTH-1.
  - FIX → DONE.
  - DONE → IDLE.
- Latency: start accepted at edge N.
  - CALC runs WIDTH cycles; FIX 1 cycle.
  - `done` is high during cycle N+WIDTH+2, i.e. WIDTH+2 cycles after `start` was sampled (34 for WIDTH=32).
- On accept, latch into internal registers: `op`, `|src0|`, `|src1|`, sign bits, `hilo_i`.
  - Magnitudes are taken only for signed ops (0, 2, 4, 6).
  - For signed ops, the most-negative value maps to unsigned 2^(WIDTH-1).
- CALC, multiply: shift-add on a 2*WIDTH-bit product register. One multiplier bit per cycle, LSB first.
- CALC, divide: restoring division on a {rem, quot} shift register. One quotient bit per cycle.
- FIX:
  - Negate the product if the operand signs differ (signed ops).
  - MADD*: result = `hilo_i` + product. MSUB*: result = `hilo_i` − product. Both modulo 2^(2*WIDTH).
  - Signed divide:
    - quotient negated if the signs differ;
    - remainder takes the dividend's sign.
  - Overflow case, e.g. 0x80000000 / 0xFFFFFFFF: quotient = 0x80000000, remainder = 0. No exception.
- Divide by zero: quotient = all-ones, remainder = src0 unmodified, `div_zero`=1. Takes full latency.
- `result` and `div_zero` hold their values until the next `done`. The pipeline reads them only in the `done` cycle.
- `start` while not IDLE: ignored. No queueing.
- `flush`:
  - In any state: FSM → IDLE next edge; `busy`=0; `done` suppressed; `result` unchanged.
  - `flush` and `start` together in IDLE: flush wins, op not accepted.
  - `flush` in the DONE cycle: `done` still pulses, since it is already registered. The consumer must gate it with its own flush.
- `rst` mid-operation: all outputs return to reset values at that edge.
- `busy` is combinational from state (state != IDLE), so it falls in the cycle after `done`.
- Back-to-back: `start` in the cycle after `done` (state IDLE) is accepted.

Test Plan:
- MULT: src0=0xFFFFFFFE (−2), src1=0x00000003 → `done` 34 cycles after `start`, `result`=0xFFFFFFFF_FFFFFFFA. MULTU with the same operands → 0x00000002_FFFFFFFA.
- MADD and MSUBU:
  - MADD: `hilo_i`=0x00000000_00000010, src0=5, src1=−3 → `result`=0x00000000_00000001.
  - MSUBU: `hilo_i`=0, src0=1, src1=1 → 0xFFFFFFFF_FFFFFFFF.
- DIV: src0=−7 (0xFFFFFFF9), src1=2 → quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. DIVU with the same operands → quotient 0x7FFFFFFC, remainder 1.
- Divide edge cases:
  - DIV 0x80000000 / 0xFFFFFFFF → `{0, 0x80000000}`, `div_zero`=0.
  - DIVU 0x1234 / 0 → `{0x00001234, 0xFFFFFFFF}`, `div_zero`=1.
- Flush and reset:
  - `flush` at cycle 10 of DIV → no `done`; `busy`=0 next cycle; `result` retains the previous value.
  - New `start` the following cycle completes correctly.
  - `rst` mid-MULT → `busy`=0, `result`=0.
- Handshake: `start` pulsed again while `busy` → ignored, exactly one `done`. `start` immediately after `done` → second op accepted, `done` 34 cycles later.
